// File: rtl/cpsr_flag_unit_pkg.sv
// Shared CPSR field positions, mode encodings and MSR mask bits for cpsr_flag_unit
// and any later flag-producing unit.
package cpsr_flag_unit_pkg;

  localparam int N_BIT = 31;
  localparam int Z_BIT = 30;
  localparam int C_BIT = 29;
  localparam int V_BIT = 28;

  localparam int MODE_HI = 4;
  localparam int MODE_LO = 0;
  localparam logic [4:0] MODE_USR = 5'b10000;

  localparam int MSR_F_BIT = 3;
  localparam int MSR_S_BIT = 2;
  localparam int MSR_X_BIT = 1;
  localparam int MSR_C_BIT = 0;

  localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

  typedef logic [3:0] nzcv_t;

  function automatic logic is_usr_mode(input logic [31:0] cpsr);
    return cpsr[MODE_HI:MODE_LO] == MODE_USR;
  endfunction

endpackage

// File: rtl/cpsr_flag_unit_flag_calc.sv
// Combinational N/Z/C/V generation from an ALU result; V is kept for logical ops.
module flag_calc
  import cpsr_flag_unit_pkg::*;
(
  input  logic [31:0] result_i,
  input  logic        carry_i,
  input  logic        overflow_i,
  input  logic        logical_i,
  input  logic        old_v_i,
  output nzcv_t       nzcv_o
);

  assign nzcv_o = {result_i[31],
                   (result_i == 32'h0),
                   carry_i,
                   logical_i ? old_v_i : overflow_i};

endmodule

// File: rtl/cpsr_flag_unit.sv
// Architectural CPSR owner plus in-flight flag-setter tracking for decode stalls.
// Optional MSR write path is enabled by defining CPSR_MSR_EN.
module cpsr_flag_unit
  import cpsr_flag_unit_pkg::*;
#(
  parameter logic [31:0] RESET_CPSR   = RESET_CPSR_DEFAULT,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        issue_i,
  input  logic        wb_valid_i,
  input  logic        wb_kill_i,
  input  logic [31:0] alu_result_i,
  input  logic        alu_carry_i,
  input  logic        alu_overflow_i,
  input  logic        logical_i,
  input  logic        flush_i,
  input  logic        msr_valid_i,
  input  logic [3:0]  msr_mask_i,
  input  logic [31:0] msr_data_i,
  output logic [31:0] cpsr_o,
  output logic        flags_busy_o,
  output logic        stall_issue_o,
  output logic        proto_err_o
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] cpsr_q, cpsr_d;
  logic        err_q, err_d;
  logic        retire;
  logic        dual_retire;
  logic        flag_upd;
  nzcv_t       nzcv;

  assign retire      = wb_valid_i | wb_kill_i;
  assign dual_retire = wb_valid_i & wb_kill_i;
  assign flag_upd    = wb_valid_i & ~wb_kill_i;

  flag_calc u_flag_calc (
    .result_i   (alu_result_i),
    .carry_i    (alu_carry_i),
    .overflow_i (alu_overflow_i),
    .logical_i  (logical_i),
    .old_v_i    (cpsr_q[V_BIT]),
    .nzcv_o     (nzcv)
  );

  // Issue and retire in the same cycle cancel, so neither bound is checked then.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | dual_retire;
    if (flush_i) begin
      cnt_d = 3'd0;
    end else if (issue_i && !retire) begin
      if (cnt_q == MAX_CNT) err_d = 1'b1;
      else                  cnt_d = cnt_q + 3'd1;
    end else if (!issue_i && retire) begin
      if (cnt_q == 3'd0) err_d = 1'b1;
      else               cnt_d = cnt_q - 3'd1;
    end
  end

  always_comb begin
    cpsr_d = cpsr_q;
    if (flag_upd) cpsr_d[N_BIT:V_BIT] = nzcv;
`ifdef CPSR_MSR_EN
    // MSR f-field is applied last so it overrides a same-cycle flag update.
    if (msr_valid_i) begin
      if (msr_mask_i[MSR_F_BIT]) cpsr_d[31:24] = msr_data_i[31:24];
      if (msr_mask_i[MSR_C_BIT] && !is_usr_mode(cpsr_q)) cpsr_d[7:0] = msr_data_i[7:0];
    end
`else
    cpsr_d[7:0] = RESET_CPSR[7:0];
`endif
  end

`ifdef CPSR_MSR_EN
  logic msr_unused;
  assign msr_unused = ^{msr_mask_i[MSR_S_BIT], msr_mask_i[MSR_X_BIT], msr_data_i[23:8]};
`else
  logic msr_unused;
  assign msr_unused = ^{msr_valid_i, msr_mask_i, msr_data_i};
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= 3'd0;
      cpsr_q <= RESET_CPSR;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      cpsr_q <= cpsr_d;
      err_q  <= err_d;
    end
  end

  assign cpsr_o        = cpsr_q;
  assign flags_busy_o  = (cnt_q != 3'd0);
  assign stall_issue_o = (cnt_q == MAX_CNT);
  assign proto_err_o   = err_q;

endmodule
